dcp_tx_arbiter: RTL and testbench
=================================

Name: dcp_tx_arbiter

Overview:
- Shares the single serial transmitter between the debug-command sub-units (DCP_P, DCP_R, DCP_D, …).
- Each sub-unit presents a req/type/dout triple. The arbiter picks one round-robin, registers its data, drives the transmitter's req_tx/type_tx/dout and routes ack_tx back.
- A per-requester lock keeps the transmitter owned by one sub-unit for a multi-word dump, so register print-outs (IMM, pc, npc, IR, CTL, A, B, Y, MDR) never interleave.

Parameters:
- NREQ, 4, number of requesting sub-units (2..8).
- DW, 32, data word width.
- TW, 2, type_tx width (transmitter's format code).
- TIMEOUT, 1023, cycles to wait for ack_tx before abort (only with the optional feature).

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset; asynchronous, active-low.
- req_in  in  NREQ  per-requester transmit request, level, held until its ack_out.
- lock_in  in  NREQ  per-requester burst lock; sampled at end of each transfer.
- type_in  in  NREQ*TW  packed type fields, slice i belongs to requester i.
- dout_in  in  NREQ*DW  packed data words, slice i belongs to requester i.
- ack_out  out  NREQ  one-cycle acknowledge to the granted requester.
- req_tx  out  1  request to transmitter, level.
- type_tx  out  TW  registered type of the current transfer.
- dout_tx  out  DW  registered data of the current transfer.
- ack_tx  in  1  transmitter done pulse.
- busy  out  1  high in any state except IDLE.
- gnt_id  out  $clog2(NREQ)  index of the current or last owner.
- err  out  1  timeout pulse; tied 0 without the optional feature.

Behaviour:
- Reset (async, rstn=0):
  - State is IDLE.
  - req_tx, ack_out, busy and err are 0; type_tx, dout_tx and gnt_id are 0.
  - The round-robin pointer is NREQ-1, so requester 0 has first priority.
- IDLE:
  - If any req_in is set, the winner is the first set bit searching upward, with wrap, from ptr+1.
  - On that edge, capture type/dout of the winner, set gnt_id, and go to SEND.
  - Latency: req_in high at edge n gives req_tx high after edge n+1.
- SEND:
  - req_tx=1; type_tx and dout_tx stay stable.
  - On ack_tx=1: req_tx drops, ack_out[gnt_id]=1 for exactly one cycle, ptr=gnt_id, go to DONE.
  - Transfer completes even if req_in[gnt_id] falls mid-SEND; the captured data is sent.
- DONE (1 cycle): the requester must drop req_in in the cycle after ack_out.
  - If lock_in[gnt_id]=1, go to HOLD; else go to IDLE.
- HOLD:
  - Other requesters are ignored.
  - req_in[gnt_id]=1: capture its data and go to SEND, same single-cycle latency as from IDLE.
  - lock_in[gnt_id]=0 with no request: go to IDLE.
  - Request and lock-drop in the same cycle: the request wins, and that transfer is the last of the burst.
- ack_tx outside SEND is ignored.
- Never more than one ack_out bit set.
- Simultaneous requests with ptr=1 and req_in=4'b1011: grant order is 3, 0, 1.
- gnt_id holds its value through IDLE.
- Reset mid-SEND aborts immediately: no ack_out, req_tx falls asynchronously.

Optional Feature:
- Macro: DCP_TXARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to SEND and increments each SEND cycle.
  - If it reaches TIMEOUT without ack_tx: req_tx=0, err=1 for one cycle, ack_out[gnt_id]=1 so the requester unblocks, lock is forced released, go to IDLE.
  - ack_tx arriving on the same cycle the counter hits TIMEOUT counts as success, with err=0.
- Undefined: no counter; SEND waits indefinitely; err is constant 0.

Decomposition:
- Shared package dcp_pkg holds:
  - state encoding ST_IDLE/ST_SEND/ST_DONE/ST_HOLD;
  - TX type codes TX_BYTE, TX_WORD, TX_STR, TX_NL;
  - default DW/TW.
- Sub-module rr_pick: a combinational round-robin priority picker (req vector and ptr in; one-hot/index and valid out), reusable by the command decoder.

Test Plan:
- Single request: req_in=4'b0001, dout_in slice0=32'h00000002, type=TX_WORD; ack_tx after 5 cycles in SEND -> req_tx rises 1 cycle after req_in, dout_tx=32'h00000002, ack_out=4'b0001 for one cycle, busy then returns 0.
- Round-robin: after reset, req_in=4'b1011 held, each requester drops req after its ack and re-raises it → grant sequence 0, 1, 3, 0; no ack_out overlap.
- Lock burst: requester 2 with lock_in[2]=1 sends 9 words 32'h1..32'h9 while requester 0 requests continuously -> all 9 words leave in order before any grant to 0; lock drop → next grant 0.
- Stray ack: ack_tx pulse in IDLE and in HOLD -> no ack_out, no state change.
- Reset mid-transfer: rstn=0 during SEND -> req_tx=0 immediately; next grant after reset goes to requester 0 even if ptr was 0.
- DCP_TXARB_TIMEOUT_EN with TIMEOUT=16 and ack_tx never asserted -> err pulse and ack_out exactly 16 SEND cycles after entry, state IDLE; rerun with ack on cycle 16 -> err=0.

Source files
------------

// File: rtl/dcp_pkg.sv
// Shared definitions for the debug-command transmit path: FSM states,
// transmitter format codes and default word widths.
package dcp_pkg;

    localparam int DCP_DW = 32;
    localparam int DCP_TW = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2,
        ST_HOLD = 2'd3
    } dcp_state_e;

    localparam logic [1:0] TX_BYTE = 2'd0;
    localparam logic [1:0] TX_WORD = 2'd1;
    localparam logic [1:0] TX_STR  = 2'd2;
    localparam logic [1:0] TX_NL   = 2'd3;

    // Index width for a vector of n requesters, never narrower than one bit.
    function automatic int dcpIdxW(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dcp_tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the transmit arbiter,
// with the arbiter view (master) and the surrounding-logic view (slave).
interface dcp_tx_arbiter_if
    import dcp_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = DCP_DW,
    parameter int TW   = DCP_TW
);

    logic [NREQ-1:0]            req_in;
    logic [NREQ-1:0]            lock_in;
    logic [NREQ*TW-1:0]         type_in;
    logic [NREQ*DW-1:0]         dout_in;
    logic [NREQ-1:0]            ack_out;
    logic                       req_tx;
    logic [TW-1:0]              type_tx;
    logic [DW-1:0]              dout_tx;
    logic                       ack_tx;
    logic                       busy;
    logic [dcpIdxW(NREQ)-1:0]   gnt_id;
    logic                       err;

    modport master (
        input  req_in, lock_in, type_in, dout_in, ack_tx,
        output ack_out, req_tx, type_tx, dout_tx, busy, gnt_id, err
    );

    modport slave (
        output req_in, lock_in, type_in, dout_in, ack_tx,
        input  ack_out, req_tx, type_tx, dout_tx, busy, gnt_id, err
    );

endinterface

// File: rtl/dcp_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Searches upward from ptr+1 with
// wrap and returns the first set request as one-hot and as an index.
module rr_pick
    import dcp_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = dcpIdxW(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    always_comb begin
        int            cand;
        logic [IW-1:0] candIdx;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        candIdx = '0;
        for (int k = 1; k <= N; k++) begin
            cand    = (int'(ptr_i) + k) % N;
            candIdx = IW'(cand);
            if (!valid_o && req_i[candIdx]) begin
                valid_o        = 1'b1;
                idx_o          = candIdx;
                gnt_o[candIdx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dcp_tx_arbiter.sv
// dcp_tx_arbiter: round-robin owner of the serial transmitter with per-requester
// burst lock. Define DCP_TXARB_TIMEOUT_EN to abort a SEND that never sees ack_tx.
module dcp_tx_arbiter
    import dcp_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DW      = DCP_DW,
    parameter int TW      = DCP_TW,
    parameter int TIMEOUT = 1023
) (
    input logic               clk,
    input logic               rstn,
    dcp_tx_arbiter_if.master  bus
);

    localparam int IW = dcpIdxW(NREQ);

    dcp_state_e      state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   gntId_q, gntId_d;
    logic [TW-1:0]   typeTx_q, typeTx_d;
    logic [DW-1:0]   doutTx_q, doutTx_d;
    logic [NREQ-1:0] ackOut_q, ackOut_d;

    logic [NREQ-1:0] reqMasked, pickGnt, gntOneHot, selVec;
    logic [IW-1:0]   pickIdx;
    logic            pickValid;
    logic [TW-1:0]   capType;
    logic [DW-1:0]   capData;
    logic            timeoutHit;

    // The requester just acknowledged may still hold req for one cycle after
    // a timeout abort; hide it so it is not instantly re-granted.
    assign reqMasked = bus.req_in & ~ackOut_q;
    assign gntOneHot = NREQ'(1) << gntId_q;

    rr_pick #(.N(NREQ)) u_pick (
        .req_i   (reqMasked),
        .ptr_i   (ptr_q),
        .gnt_o   (pickGnt),
        .idx_o   (pickIdx),
        .valid_o (pickValid)
    );

    always_comb begin
        selVec  = (state_q == ST_IDLE) ? pickGnt : gntOneHot;
        capType = '0;
        capData = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (selVec[i]) begin
                capType = capType | bus.type_in[i*TW +: TW];
                capData = capData | bus.dout_in[i*DW +: DW];
            end
        end
    end

`ifdef DCP_TXARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q;
    logic          err_q;

    assign timeoutHit = (state_q == ST_SEND) && !bus.ack_tx && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= (state_q == ST_SEND) ? cnt_q + 1'b1 : '0;
            err_q <= timeoutHit;
        end
    end
`else
    assign timeoutHit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            ptr_q    <= IW'(NREQ - 1);
            gntId_q  <= '0;
            typeTx_q <= '0;
            doutTx_q <= '0;
            ackOut_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gntId_q  <= gntId_d;
            typeTx_q <= typeTx_d;
            doutTx_q <= doutTx_d;
            ackOut_q <= ackOut_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gntId_d  = gntId_q;
        typeTx_d = typeTx_q;
        doutTx_d = doutTx_q;
        ackOut_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (pickValid) begin
                    gntId_d  = pickIdx;
                    typeTx_d = capType;
                    doutTx_d = capData;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                // ack_tx wins over a timeout landing on the same cycle.
                if (bus.ack_tx) begin
                    ackOut_d = gntOneHot;
                    ptr_d    = gntId_q;
                    state_d  = ST_DONE;
                end else if (timeoutHit) begin
                    ackOut_d = gntOneHot;
                    ptr_d    = gntId_q;
                    state_d  = ST_IDLE;
                end
            end
            ST_DONE: begin
                state_d = bus.lock_in[gntId_q] ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                if (bus.req_in[gntId_q]) begin
                    typeTx_d = capType;
                    doutTx_d = capData;
                    state_d  = ST_SEND;
                end else if (!bus.lock_in[gntId_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_tx  = (state_q == ST_SEND);
        bus.busy    = (state_q != ST_IDLE);
        bus.ack_out = ackOut_q;
        bus.type_tx = typeTx_q;
        bus.dout_tx = doutTx_q;
        bus.gnt_id  = gntId_q;
`ifdef DCP_TXARB_TIMEOUT_EN
        bus.err     = err_q;
`else
        bus.err     = 1'b0;
`endif
    end

endmodule

// File: tb/tb_dcp_tx_arbiter.sv
// tb_dcp_tx_arbiter: vector table, hand-written corner sequences and a random
// run against a transaction-level round-robin model of dcp_tx_arbiter.
module tb_dcp_tx_arbiter;
    import dcp_pkg::*;

    localparam int NREQ      = 4;
    localparam int DW        = 32;
    localparam int TW        = 2;
    localparam int TIMEOUT_P = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    dcp_tx_arbiter_if #(.NREQ(NREQ), .DW(DW), .TW(TW)) bus ();

    dcp_tx_arbiter #(.NREQ(NREQ), .DW(DW), .TW(TW), .TIMEOUT(TIMEOUT_P)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        logic [NREQ-1:0] req;
        logic [NREQ-1:0] lock;
        logic            ack;
        logic            expReqTx;
        logic            expBusy;
        logic [NREQ-1:0] expAck;
        int              expGnt;
    } vec_t;

    vec_t            vecs[$];
    int              nCompared   = 0;
    int              nMismatched = 0;
    logic [TW-1:0]   mType[NREQ];
    logic [DW-1:0]   mData[NREQ];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] req, input logic [NREQ-1:0] lock,
                                 input logic ack);
        bus.req_in  = req;
        bus.lock_in = lock;
        bus.ack_tx  = ack;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic setSlot(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
        bus.type_in[i*TW +: TW] = t;
        bus.dout_in[i*DW +: DW] = d;
        mType[i] = t;
        mData[i] = d;
    endtask

    function automatic vec_t mk(input logic [NREQ-1:0] req, input logic ack, input logic eReq,
                                input logic eBusy, input logic [NREQ-1:0] eAck, input int eGnt);
        vec_t v;
        v.req = req; v.lock = '0; v.ack = ack;
        v.expReqTx = eReq; v.expBusy = eBusy; v.expAck = eAck; v.expGnt = eGnt;
        return v;
    endfunction

    // Reference rule: walk the requesters in rotation order starting after the last owner.
    function automatic int modelPick(input logic [NREQ-1:0] pending, input int last);
        int order[$];
        for (int k = 0; k < NREQ; k++) order.push_back((last + 1 + k) % NREQ);
        foreach (order[i]) if (pending[order[i]]) return order[i];
        return -1;
    endfunction

    task automatic resetDut(input bit doCheck);
        rstn = 1'b0;
        applyStimulus('0, '0, 1'b0);
        tick();
        tick();
        if (doCheck) begin
            checkOutput("rst reqTx",  bus.req_tx,  0);
            checkOutput("rst busy",   bus.busy,    0);
            checkOutput("rst ackOut", bus.ack_out, 0);
            checkOutput("rst gntId",  bus.gnt_id,  0);
            checkOutput("rst typeTx", bus.type_tx, 0);
            checkOutput("rst doutTx", bus.dout_tx, 0);
            checkOutput("rst err",    bus.err,     0);
        end
        rstn = 1'b1;
    endtask

    task automatic waitReqTx(input string name);
        int n = 0;
        while (bus.req_tx !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        checkOutput({name, " reqTx rise"}, bus.req_tx, 1);
    endtask

    // Leaves the bench in the DONE cycle, right after ack_out was checked.
    task automatic transfer(input int expId, input logic [TW-1:0] expType,
                            input logic [DW-1:0] expData, input int ackDelay);
        waitReqTx("xfer");
        checkOutput("gntId",  bus.gnt_id,  expId);
        checkOutput("typeTx", bus.type_tx, expType);
        checkOutput("doutTx", bus.dout_tx, expData);
        repeat (ackDelay) tick();
        bus.ack_tx = 1'b1;
        tick();
        bus.ack_tx = 1'b0;
        checkOutput("ackOut",    bus.ack_out, 64'(1) << expId);
        checkOutput("reqTxDrop", bus.req_tx,  0);
    endtask

    initial begin
        #500000;
        $display("[TB] watchdog expired before the summary");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int rrExp[4] = '{0, 1, 3, 0};
        logic [NREQ-1:0] pending;
        logic [NREQ-1:0] extra;
        int last;
        int expId;

        setSlot(0, TX_WORD, 32'h0000_0002);
        setSlot(1, TX_BYTE, 32'h0000_0011);
        setSlot(2, TX_STR,  32'h0000_0022);
        setSlot(3, TX_NL,   32'h0000_0033);
        resetDut(1'b1);

        // Single request, ack after 5 SEND cycles, then a stray ack in IDLE.
        vecs.push_back(mk(4'b0001, 1'b0, 1'b1, 1'b1, 4'b0000, 0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(4'b0001, 1'b0, 1'b1, 1'b1, 4'b0000, 0));
        vecs.push_back(mk(4'b0001, 1'b1, 1'b0, 1'b1, 4'b0001, 0));
        vecs.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 0));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 0));
        vecs.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 0));
        foreach (vecs[k]) begin
            applyStimulus(vecs[k].req, vecs[k].lock, vecs[k].ack);
            tick();
            checkOutput($sformatf("vec%0d reqTx", k),  bus.req_tx,  vecs[k].expReqTx);
            checkOutput($sformatf("vec%0d busy", k),   bus.busy,    vecs[k].expBusy);
            checkOutput($sformatf("vec%0d ackOut", k), bus.ack_out, vecs[k].expAck);
            checkOutput($sformatf("vec%0d gntId", k),  bus.gnt_id,  vecs[k].expGnt);
        end
        checkOutput("single doutTx", bus.dout_tx, 32'h0000_0002);
        checkOutput("single typeTx", bus.type_tx, TX_WORD);

        // Round robin from reset with 1011 held.
        resetDut(1'b0);
        applyStimulus(4'b1011, '0, 1'b0);
        for (int g = 0; g < 4; g++) begin
            transfer(rrExp[g], mType[rrExp[g]], mData[rrExp[g]], 2);
            bus.req_in[rrExp[g]] = 1'b0;
            tick();
            checkOutput("rr idle ackOut", bus.ack_out, 0);
            bus.req_in[rrExp[g]] = 1'b1;
        end
        applyStimulus('0, '0, 1'b0);

        // Locked nine-word burst from requester 2 while requester 0 waits.
        setSlot(0, TX_BYTE, 32'h0000_00A0);
        setSlot(2, TX_WORD, 32'h0000_0001);
        applyStimulus(4'b0101, 4'b0100, 1'b0);
        for (int w = 1; w <= 9; w++) begin
            if (w > 1) begin
                bus.req_in[2] = 1'b0;
                tick();
                checkOutput("hold busy",  bus.busy,   1);
                checkOutput("hold reqTx", bus.req_tx, 0);
                if (w == 4) begin
                    bus.ack_tx = 1'b1;
                    tick();
                    bus.ack_tx = 1'b0;
                    checkOutput("hold stray ackOut", bus.ack_out, 0);
                    checkOutput("hold stray busy",   bus.busy,    1);
                    checkOutput("hold stray reqTx",  bus.req_tx,  0);
                end
                setSlot(2, TX_WORD, DW'(w));
                bus.req_in[2] = 1'b1;
                if (w == 9) bus.lock_in[2] = 1'b0;
            end
            transfer(2, TX_WORD, DW'(w), w % 3);
        end
        bus.req_in[2] = 1'b0;
        tick();
        checkOutput("burst end busy", bus.busy, 0);
        transfer(0, TX_BYTE, 32'h0000_00A0, 1);
        bus.req_in[0] = 1'b0;
        tick();

        // Reset in the middle of a SEND.
        applyStimulus(4'b0011, '0, 1'b0);
        waitReqTx("rst pre");
        checkOutput("rst pre gntId", bus.gnt_id, 1);
        tick();
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("rst mid reqTx",  bus.req_tx,  0);
        checkOutput("rst mid busy",   bus.busy,    0);
        checkOutput("rst mid ackOut", bus.ack_out, 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        transfer(0, mType[0], mData[0], 0);
        applyStimulus('0, '0, 1'b0);
        tick();

`ifdef DCP_TXARB_TIMEOUT_EN
        applyStimulus(4'b0010, 4'b0010, 1'b0);
        tick();
        repeat (TIMEOUT_P - 1) tick();
        checkOutput("to last reqTx", bus.req_tx, 1);
        checkOutput("to last err",   bus.err,    0);
        tick();
        checkOutput("to err",    bus.err,     1);
        checkOutput("to ackOut", bus.ack_out, 4'b0010);
        checkOutput("to busy",   bus.busy,    0);
        checkOutput("to reqTx",  bus.req_tx,  0);
        bus.req_in = '0;
        tick();
        checkOutput("to err clear", bus.err,     0);
        checkOutput("to ack clear", bus.ack_out, 0);
        checkOutput("to unlocked",  bus.busy,    0);
        applyStimulus(4'b0010, '0, 1'b0);
        tick();
        repeat (TIMEOUT_P - 1) tick();
        bus.ack_tx = 1'b1;
        tick();
        bus.ack_tx = 1'b0;
        checkOutput("to edge err",    bus.err,     0);
        checkOutput("to edge ackOut", bus.ack_out, 4'b0010);
        checkOutput("to edge busy",   bus.busy,    1);
`else
        applyStimulus(4'b0010, '0, 1'b0);
        tick();
        repeat (40) tick();
        checkOutput("long send reqTx", bus.req_tx, 1);
        checkOutput("long send err",   bus.err,    0);
        bus.ack_tx = 1'b1;
        tick();
        bus.ack_tx = 1'b0;
        checkOutput("long send ackOut", bus.ack_out, 4'b0010);
`endif
        applyStimulus('0, '0, 1'b0);
        tick();

        // Random traffic against the rotation model.
        resetDut(1'b0);
        last    = NREQ - 1;
        pending = '0;
        for (int t = 0; t < 40; t++) begin
            if (pending == '0) begin
                pending = NREQ'($urandom_range(1, (1 << NREQ) - 1));
                for (int i = 0; i < NREQ; i++)
                    if (pending[i]) setSlot(i, TW'($urandom_range(0, 3)), DW'($urandom));
            end
            bus.req_in = pending;
            expId = modelPick(pending, last);
            transfer(expId, mType[expId], mData[expId], $urandom_range(0, 3));
            pending[expId] = 1'b0;
            extra = NREQ'($urandom_range(0, (1 << NREQ) - 1)) & ~pending & ~(NREQ'(1) << expId);
            for (int i = 0; i < NREQ; i++)
                if (extra[i]) setSlot(i, TW'($urandom_range(0, 3)), DW'($urandom));
            pending    = pending | extra;
            bus.req_in = pending;
            tick();
            checkOutput("rnd idle busy", bus.busy, 0);
            last = expId;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
